// File: rtl/btb_pkg.sv
// Shared types and register map for the BTB controller.
package btb_pkg;

  typedef enum logic [1:0] {
    StInit,
    StFlush,
    StIdle
  } btb_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_HIT    = 2'd2;
  localparam logic [1:0] REG_MISP   = 2'd3;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_EN_BIT    = 1;

endpackage

// File: rtl/btb_sat_cnt.sv
// 16-bit saturating event counter; clear has priority over increment.
module btb_sat_cnt (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/btb_ctrl.sv
// BTB controller: enable, invalidation sweeps, write-port arbitration and MMIO registers.
// Statistics counters are built only when BTB_STATS_EN is defined.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] BASE_ADDR = 16'hC010,
  parameter logic        EN_RST    = 1'b0,
  localparam int unsigned IDX_W    = $clog2(ENTRIES),
  localparam int unsigned TAG_W    = ADDR_W - IDX_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_mm_addr,
  input  logic              i_mm_we,
  input  logic              i_mm_re,
  input  logic [15:0]       i_mm_wdata,
  output logic [15:0]       o_mm_rdata,
  input  logic              i_upd_vld,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic [ADDR_W-1:0] i_upd_target,
  input  logic              i_upd_taken,
  input  logic              i_upd_mispred,
  input  logic              i_lookup_hit,
  output logic              o_btb_en,
  output logic              o_btb_we,
  output logic [IDX_W-1:0]  o_btb_widx,
  output logic [TAG_W-1:0]  o_btb_wtag,
  output logic [ADDR_W-1:0] o_btb_wtarget,
  output logic              o_btb_wvalid,
  output logic              o_busy
);

  btb_state_e       r_state;
  logic [IDX_W-1:0] r_sweep_idx;
  logic             r_en;

  logic [15:0] w_off;
  logic        w_sel;
  logic [1:0]  w_reg;
  logic        w_ctrl_wr;
  logic        w_idle;
  logic        w_btb_en;
  logic [15:0] w_hit_cnt;
  logic [15:0] w_misp_cnt;
  logic        unused_in;

  // Offset subtraction wraps, so addresses below the base fall outside the window.
  assign w_off     = i_mm_addr - BASE_ADDR;
  assign w_sel     = (w_off[15:2] == 14'd0);
  assign w_reg     = w_off[1:0];
  assign w_ctrl_wr = i_mm_we && w_sel && (w_reg == REG_CTRL);
  assign w_idle    = (r_state == StIdle);
  assign w_btb_en  = r_en && w_idle;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StInit;
      r_sweep_idx <= '0;
      r_en        <= EN_RST;
    end else begin
      if (w_ctrl_wr) r_en <= i_mm_wdata[CTRL_EN_BIT];
      case (r_state)
        StInit: begin
          r_state     <= StFlush;
          r_sweep_idx <= '0;
        end
        StFlush: begin
          r_sweep_idx <= r_sweep_idx + 1'b1;
          if (r_sweep_idx == IDX_W'(ENTRIES - 1)) r_state <= StIdle;
        end
        StIdle: begin
          if (w_ctrl_wr && i_mm_wdata[CTRL_FLUSH_BIT]) begin
            r_state     <= StFlush;
            r_sweep_idx <= '0;
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  // The sweep owns the write port; resolve updates get it only when the BTB is live.
  always_comb begin
    o_btb_we      = 1'b0;
    o_btb_widx    = '0;
    o_btb_wtag    = '0;
    o_btb_wtarget = '0;
    o_btb_wvalid  = 1'b0;
    if (r_state == StFlush) begin
      o_btb_we   = 1'b1;
      o_btb_widx = r_sweep_idx;
    end else if (w_btb_en && i_upd_vld) begin
      o_btb_we      = 1'b1;
      o_btb_widx    = i_upd_pc[IDX_W-1:0];
      o_btb_wtag    = i_upd_pc[ADDR_W-1:IDX_W];
      o_btb_wtarget = i_upd_target;
      o_btb_wvalid  = i_upd_taken;
    end
  end

`ifdef BTB_STATS_EN
  btb_sat_cnt u_hit_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_lookup_hit && w_btb_en),
    .i_clr (i_mm_we && w_sel && (w_reg == REG_HIT)),
    .o_cnt (w_hit_cnt)
  );

  btb_sat_cnt u_misp_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_upd_vld && i_upd_mispred && w_btb_en),
    .i_clr (i_mm_we && w_sel && (w_reg == REG_MISP)),
    .o_cnt (w_misp_cnt)
  );

  assign unused_in = ^i_mm_wdata[15:2];
`else
  assign w_hit_cnt  = '0;
  assign w_misp_cnt = '0;
  assign unused_in  = ^{i_mm_wdata[15:2], i_lookup_hit, i_upd_mispred};
`endif

  always_comb begin
    o_mm_rdata = '0;
    if (i_mm_re && w_sel) begin
      case (w_reg)
        REG_CTRL:   o_mm_rdata[CTRL_EN_BIT] = r_en;
        REG_STATUS: begin
          o_mm_rdata[STAT_BUSY_BIT] = !w_idle;
          o_mm_rdata[STAT_EN_BIT]   = w_btb_en;
        end
        REG_HIT:    o_mm_rdata = w_hit_cnt;
        REG_MISP:   o_mm_rdata = w_misp_cnt;
        default:    o_mm_rdata = '0;
      endcase
    end
  end

  assign o_btb_en = w_btb_en;
  assign o_busy   = !w_idle;

endmodule

// File: tb/tb_btb_ctrl.sv
// Scoreboard bench for btb_ctrl: directed scenarios followed by randomized traffic.
module tb_btb_ctrl;

  localparam logic [15:0] BASE = 16'hC010;
  localparam int NENT = 16;
`ifdef BTB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, mm_we, mm_re, upd_vld, upd_taken, upd_mispred, lookup_hit;
  logic [15:0] mm_addr, mm_wdata, mm_rdata, upd_pc, upd_target, btb_wtarget;
  logic        btb_en, btb_we, btb_wvalid, busy;
  logic [3:0]  btb_widx;
  logic [11:0] btb_wtag;

  always #5 clk = ~clk;

  btb_ctrl dut (
    .i_clk (clk), .i_rst (rst),
    .i_mm_addr (mm_addr), .i_mm_we (mm_we), .i_mm_re (mm_re),
    .i_mm_wdata (mm_wdata), .o_mm_rdata (mm_rdata),
    .i_upd_vld (upd_vld), .i_upd_pc (upd_pc), .i_upd_target (upd_target),
    .i_upd_taken (upd_taken), .i_upd_mispred (upd_mispred), .i_lookup_hit (lookup_hit),
    .o_btb_en (btb_en), .o_btb_we (btb_we), .o_btb_widx (btb_widx), .o_btb_wtag (btb_wtag),
    .o_btb_wtarget (btb_wtarget), .o_btb_wvalid (btb_wvalid), .o_busy (busy)
  );

  typedef struct {
    bit rst; logic [15:0] addr; bit we; bit re; logic [15:0] wd;
    bit uv; logic [15:0] pc; logic [15:0] tgt; bit tk; bit mp; bit hit;
  } stim_t;

  typedef struct {
    logic [15:0] rdata; logic we; logic [3:0] widx; logic [11:0] wtag;
    logic [15:0] wtarget; logic wvalid; logic busy; logic btb_en; bit chk_fields;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_pass  = 0;

  // Reference state: sweep progress as a count of remaining invalidations.
  bit m_known = 0;
  bit m_init  = 0;
  int m_left  = 0;
  bit m_en    = 0;
  int m_hit   = 0;
  int m_misp  = 0;

  function automatic stim_t nop();
    stim_t s;
    s = '{rst: 0, addr: 16'h0000, we: 0, re: 0, wd: 16'h0, uv: 0, pc: 16'h0, tgt: 16'h0,
          tk: 0, mp: 0, hit: 0};
    return s;
  endfunction

  task automatic tick(input stim_t s);
    exp_t        e;
    logic [15:0] off;
    bit          sel, idle, ben;
    rst = s.rst; mm_addr = s.addr; mm_we = s.we; mm_re = s.re; mm_wdata = s.wd;
    upd_vld = s.uv; upd_pc = s.pc; upd_target = s.tgt; upd_taken = s.tk;
    upd_mispred = s.mp; lookup_hit = s.hit;

    off  = s.addr - BASE;
    sel  = (off < 16'd4);
    idle = !m_init && (m_left == 0);
    ben  = m_en && idle;
    e = '{rdata: 16'h0, we: 0, widx: 4'h0, wtag: 12'h0, wtarget: 16'h0, wvalid: 0,
          busy: !idle, btb_en: ben, chk_fields: 1};
    if (m_init) begin
      e.we = 0;
    end else if (m_left > 0) begin
      e.we = 1; e.widx = 4'(NENT - m_left);
    end else if (s.uv && ben) begin
      e.we = 1; e.widx = s.pc[3:0]; e.wtag = s.pc[15:4]; e.wtarget = s.tgt; e.wvalid = s.tk;
    end else begin
      e.chk_fields = 0;
    end
    if (s.re && sel) begin
      case (off)
        16'd0:   e.rdata = {15'd0, m_en};
        16'd1:   e.rdata = {14'd0, ben, !idle};
        16'd2:   e.rdata = STATS ? 16'(m_hit) : 16'h0;
        default: e.rdata = STATS ? 16'(m_misp) : 16'h0;
      endcase
    end
    if (m_known) q.push_back(e);

    if (s.rst) begin
      m_known = 1; m_init = 1; m_left = 0; m_en = 0; m_hit = 0; m_misp = 0;
    end else begin
      if (STATS) begin
        if (s.we && sel && off == 16'd2) m_hit = 0;
        else if (s.hit && ben && m_hit < 65535) m_hit++;
        if (s.we && sel && off == 16'd3) m_misp = 0;
        else if (s.uv && s.mp && ben && m_misp < 65535) m_misp++;
      end
      if (m_init) begin
        m_init = 0; m_left = NENT;
      end else if (m_left > 0) begin
        m_left--;
      end else if (s.we && sel && off == 16'd0 && s.wd[1]) begin
        m_left = NENT;
      end
      if (s.we && sel && off == 16'd0) m_en = s.wd[0];
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("btb_en", 32'(btb_en), 32'(e.btb_en));
      chk("btb_we", 32'(btb_we), 32'(e.we));
      chk("mm_rdata", 32'(mm_rdata), 32'(e.rdata));
      if (e.chk_fields) begin
        chk("btb_widx", 32'(btb_widx), 32'(e.widx));
        chk("btb_wtag", 32'(btb_wtag), 32'(e.wtag));
        chk("btb_wtarget", 32'(btb_wtarget), 32'(e.wtarget));
        chk("btb_wvalid", 32'(btb_wvalid), 32'(e.wvalid));
      end
    end
  end

  initial begin
    stim_t s;
    // Reset and power-on sweep, polling STATUS throughout.
    s = nop(); s.rst = 1; tick(s); tick(s);
    s = nop(); s.re = 1; s.addr = BASE + 16'd1;
    repeat (20) tick(s);

    // Enable, then a taken update.
    s = nop(); s.we = 1; s.addr = BASE; s.wd = 16'h0001; tick(s);
    s = nop(); s.uv = 1; s.pc = 16'h0123; s.tgt = 16'h0200; s.tk = 1; tick(s);

    // Flush together with an update, then updates during the sweep.
    s = nop(); s.we = 1; s.addr = BASE; s.wd = 16'h0003;
    s.uv = 1; s.pc = 16'h0456; s.tgt = 16'h0800; s.tk = 1; tick(s);
    for (int i = 0; i < 18; i++) begin
      s = nop(); s.re = 1; s.addr = BASE + 16'd1; s.uv = 1; s.pc = 16'($urandom);
      s.tk = 1; tick(s);
    end

    // Second flush request mid-sweep must be ignored.
    s = nop(); s.we = 1; s.addr = BASE; s.wd = 16'h0003; tick(s);
    s = nop(); repeat (5) tick(s);
    s = nop(); s.we = 1; s.addr = BASE; s.wd = 16'h0003; tick(s);
    s = nop(); s.re = 1; s.addr = BASE + 16'd1; repeat (14) tick(s);

    // Reset while the sweep shows index 7.
    s = nop(); s.we = 1; s.addr = BASE; s.wd = 16'h0003; tick(s);
    s = nop(); repeat (7) tick(s);
    s = nop(); s.rst = 1; tick(s);
    s = nop(); s.re = 1; s.addr = BASE + 16'd1; repeat (20) tick(s);

    // Statistics: hits, read back, clear racing a hit; offset 2 reads 0 without stats.
    s = nop(); s.we = 1; s.addr = BASE; s.wd = 16'h0001; tick(s);
    s = nop(); s.hit = 1; repeat (3) tick(s);
    s = nop(); s.re = 1; s.addr = BASE + 16'd2; tick(s);
    s = nop(); s.we = 1; s.addr = BASE + 16'd2; s.hit = 1; tick(s);
    s = nop(); s.re = 1; s.addr = BASE + 16'd2; tick(s);
    s = nop(); s.uv = 1; s.mp = 1; s.re = 1; s.addr = BASE + 16'd3; repeat (3) tick(s);
`ifdef BTB_STATS_EN
    // Saturation: count up to 16'hFFFE, then three more hits.
    s = nop(); s.we = 1; s.addr = BASE + 16'd2; tick(s);
    s = nop(); s.hit = 1; repeat (65534) tick(s);
    s = nop(); s.re = 1; s.addr = BASE + 16'd2; tick(s);
    s = nop(); s.hit = 1; s.re = 1; s.addr = BASE + 16'd2; repeat (3) tick(s);
    s = nop(); s.re = 1; s.addr = BASE + 16'd2; tick(s);
`endif

    // Randomized traffic, including out-of-window addresses and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      s = nop();
      s.rst  = ($urandom_range(0, 299) == 0);
      s.addr = BASE + 16'($urandom_range(0, 5)) - 16'd1;
      s.we   = ($urandom_range(0, 5) == 0);
      s.re   = $urandom_range(0, 1) == 1;
      s.wd   = 16'($urandom);
      if ($urandom_range(0, 3) != 0) s.wd[1] = 1'b0;
      s.uv   = $urandom_range(0, 1) == 1;
      s.pc   = 16'($urandom);
      s.tgt  = 16'($urandom);
      s.tk   = $urandom_range(0, 1) == 1;
      s.mp   = $urandom_range(0, 1) == 1;
      s.hit  = $urandom_range(0, 1) == 1;
      tick(s);
    end
    s = nop(); tick(s);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
